// File: rtl/multiplier.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, 34-edge latency.
// Define MULT_EARLY_OUT_EN to leave the iteration loop once the remaining multiplier bits are zero.
module multiplier (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] P,
    output logic        ok
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t      state;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  cycle;
    logic        neg;
    logic [1:0]  opsel;

    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mplier_next;
    logic [63:0] prod;
    logic        done_early;

    // A is signed for every op except MULHU; B is signed only for MUL and MULH.
    assign sign_a      = A[31] & (op != 2'b11);
    assign sign_b      = B[31] & ~op[1];
    assign mag_a       = sign_a ? (~A + 32'd1) : A;
    assign mag_b       = sign_b ? (~B + 32'd1) : B;
    assign mplier_next = mplier >> 1;
    assign prod        = neg ? (~acc + 64'd1) : acc;

`ifdef MULT_EARLY_OUT_EN
    assign done_early = (mplier_next == 32'd0);
`else
    assign done_early = 1'b0;
`endif

    // A start in any state restarts the loop; an aborted operation never touches P.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            P      <= 32'd0;
            ok     <= 1'b1;
            acc    <= 64'd0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            cycle  <= 5'd0;
            neg    <= 1'b0;
            opsel  <= 2'b00;
        end else if (start) begin
            state  <= RUN;
            ok     <= 1'b0;
            acc    <= 64'd0;
            mcand  <= {32'd0, mag_a};
            mplier <= mag_b;
            cycle  <= 5'd31;
            neg    <= sign_a ^ sign_b;
            opsel  <= op;
        end else begin
            case (state)
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    cycle  <= cycle - 5'd1;
                    if ((cycle == 5'd0) || done_early) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    P     <= (opsel == 2'b00) ? prod[31:0] : prod[63:32];
                    state <= IDLE;
                    ok    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ok    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed RV32M cases, restart/reset mid-operation, random operands.
// Expected products and latencies are queued at issue and compared when ok returns.
module tb_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] P;
    logic        ok;

    int          checks;
    int          failures;
    int          edge_cnt;
    int          start_edge;
    logic [31:0] last_p;
    logic [31:0] exp_q[$];
    int          lat_q[$];

`ifdef MULT_EARLY_OUT_EN
    localparam int RESTART_WAIT = 2;
`else
    localparam int RESTART_WAIT = 10;
`endif

    multiplier dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .P     (P),
        .ok    (ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference product from full-width signed arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ea;
        logic signed [65:0] eb;
        logic signed [65:0] pr;
        ea = {{34{a[31] & (o != 2'b11)}}, a};
        eb = {{34{b[31] & ~o[1]}}, b};
        pr = ea * eb;
        return (o == 2'b00) ? pr[31:0] : pr[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int          k;
        m = (b[31] & ~o[1]) ? (~b + 32'd1) : b;
        k = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) k = i + 1;
        end
`ifdef MULT_EARLY_OUT_EN
        return 2 + ((k < 1) ? 1 : k);
`else
        return (k >= 0) ? 34 : 0;
`endif
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_p, input bit keep);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_edge = edge_cnt;
        if (keep) begin
            exp_q.push_back(exp_p);
            lat_q.push_back(exp_lat(o, b));
        end
    endtask

    task automatic checkOutput(input string tag);
        int          waited;
        int          lat;
        int          exp_l;
        logic [31:0] exp_p;
        waited = 0;
        while (!ok && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check32({tag, "_done"}, {31'd0, ok}, 32'd1);
        lat   = edge_cnt - start_edge + 1;
        exp_l = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
        exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check32({tag, "_latency"}, lat, exp_l);
        check32({tag, "_P"}, P, exp_p);
        last_p = exp_p;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        checks   = 0;
        failures = 0;
        last_p   = 32'd0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        A        = 32'd0;
        B        = 32'd0;
        start_edge = 0;

        @(posedge clk);
        @(posedge clk);
        #1;
        check32("reset_ok", {31'd0, ok}, 32'd1);
        check32("reset_P", P, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed products");
        applyStimulus(2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b1);
        check32("mul_ok_low", {31'd0, ok}, 32'd0);
        checkOutput("mul_7x6");
        applyStimulus(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
        checkOutput("mulh_min_min");
        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        checkOutput("mulh_m1_m1");
        applyStimulus(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        checkOutput("mulhsu_m1");
        applyStimulus(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        checkOutput("mulhu_max");
        applyStimulus(2'b00, 32'h12345678, 32'd1, 32'h12345678, 1'b1);
        checkOutput("mul_by_one");
        applyStimulus(2'b00, 32'h12345678, 32'd0, 32'h00000000, 1'b1);
        checkOutput("mul_by_zero");
        applyStimulus(2'b00, 32'h00000003, 32'h80000000, 32'h80000000, 1'b1);
        checkOutput("mul_by_min");

        $display("[TB] restart mid-operation");
        applyStimulus(2'b00, 32'd3, 32'd5, 32'd15, 1'b0);
        for (int i = 0; i < RESTART_WAIT; i++) begin
            @(posedge clk);
            #1;
        end
        check32("restart_busy", {31'd0, ok}, 32'd0);
        check32("restart_hold_P", P, last_p);
        applyStimulus(2'b00, 32'd9, 32'd9, 32'h00000051, 1'b1);
        @(posedge clk);
        #1;
        check32("restart_hold_P2", P, last_p);
        checkOutput("restart_9x9");

        $display("[TB] reset mid-operation");
        applyStimulus(2'b11, 32'h0000ABCD, 32'hFFFFFFFF, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        A     = 32'd5;
        B     = 32'd5;
        @(posedge clk);
        #1;
        check32("midreset_ok", {31'd0, ok}, 32'd1);
        check32("midreset_P", P, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        start  = 1'b0;
        last_p = 32'd0;
        @(posedge clk);
        #1;
        check32("start_ignored_in_reset", {31'd0, ok}, 32'd1);
        applyStimulus(2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 1'b1);
        checkOutput("mulhu_after_reset");

        $display("[TB] random operands");
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 255));
            applyStimulus(ro, ra, rb, model(ro, ra, rb), 1'b1);
            checkOutput("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplier.md
# multiplier

Iterative radix-2 integer multiplier for the RV32M MUL/MULH/MULHSU/MULHU group. It is the multiply counterpart to the sequential integer divider and sits beside it in the execute stage. Both blocks share the same start/ok handshake, so the issue logic drives them identically. The block converts operands to magnitudes, runs a shift-add loop, applies the sign correction, and returns the selected 32-bit half of the 64-bit product.

## Interface
- No parameters; datapath fixed at 32-bit operands, 64-bit internal product.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; samples A, B, op on the same edge.
- op  input  2  00 MUL (low word, signed×signed), 01 MULH (high, s×s), 10 MULHSU (high, A signed × B unsigned), 11 MULHU (high, u×u).
- A  input  32  multiplicand (rs1).
- B  input  32  multiplier (rs2).
- P  output  32  selected product word; registered.
- ok  output  1  high when idle and P is valid; low while an operation is in flight.

## Operation
- States: IDLE, RUN, FIX. ok = (state == IDLE).
- On start, in any state, latch the following and enter RUN with cycle = 31:
  - sign_a = A[31] & (op != 11); sign_b = B[31] & (op == 00 | op == 01).
  - mcand[63:0] = zero-extended |A| (two's-complement negate if sign_a).
  - mplier[31:0] = |B| (negate if sign_b); acc = 0; neg = sign_a ^ sign_b; opsel = op.
- Magnitude of 0x80000000 is 0x80000000 as unsigned; no overflow case exists.
- RUN, each edge:
  - If mplier[0], then acc <= acc + mcand (64-bit, carry out discarded).
  - mcand <<= 1; mplier >>= 1; cycle <= cycle − 1.
  - Leave for FIX on the edge where cycle == 0.
- FIX, one edge:
  - prod = neg ? −acc : acc (64-bit two's complement).
  - P <= (opsel == 00) ? prod[31:0] : prod[63:32].
  - Go to IDLE.
- P changes only in FIX or reset. It holds the previous result throughout RUN.
- A start while in RUN or FIX aborts the current operation without updating P and restarts with the new operands.
- Reset, including mid-operation: state IDLE, P = 0, acc/mcand/mplier/cycle = 0, ok = 1. start is ignored in a cycle where reset is high.

## Timing
- Edge N samples start: ok falls after edge N.
- Edges N+1 through N+32 are RUN iterations. Edge N+33 is FIX.
- ok rises and P is valid after edge N+33, which gives a fixed latency of 34 edges.
- The consumer may issue the next start in the same cycle that ok is first high.
- Inputs A, B, op are don't-care except on the start edge.

## Configuration
- MULT_EARLY_OUT_EN, when defined:
  - RUN also exits to FIX on any edge where the post-shift mplier is zero.
  - A minimum of one RUN iteration is always performed.
  - Latency = 2 + max(1, k) edges, where k is the bit position of the highest set bit of |B| plus one.
  - Results are identical to the fixed-latency build.
- Undefined: fixed 32 iterations and a 34-edge latency for every operand.

## Test plan
- MUL A=7, B=6 → after 34 edges ok=1, P=0x0000002A; ok low for exactly 33 cycles.
- MULH A=0x80000000, B=0x80000000 → P=0x40000000. MULH A=0xFFFFFFFF, B=0xFFFFFFFF → P=0x00000000.
- MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → P=0xFFFFFFFF. MULHU with the same operands → P=0xFFFFFFFE.
- Restart mid-op:
  - MUL 3×5 is started; at RUN cycle 10, start MUL 9×9.
  - P stays at its old value until the second operation completes 34 edges after the restart, then P=0x00000051.
- Reset mid-op:
  - Assert reset at RUN cycle 20 → next edge ok=1, P=0.
  - A following MULHU 0x10000×0x10000 → P=0x00000001.
- Early-out (MULT_EARLY_OUT_EN defined):
  - MUL A=0x12345678, B=1 → ok after 3 edges, P=0x12345678.
  - B=0 → 3 edges, P=0.
  - B=0x80000000 → 34 edges.
